// File: rtl/boreal_pkg.sv
// Shared types and constants for the Boreal Neuro-Core learning sequencer.
package boreal_pkg;

  typedef enum logic [1:0] {
    SCHED_IDLE  = 2'd0,
    SCHED_RUN   = 2'd1,
    SCHED_DRAIN = 2'd2,
    SCHED_DONE  = 2'd3
  } sched_state_e;

  localparam int BOREAL_DW       = 16;
  localparam int SCHED_DRAIN_CYC = 2;

endpackage

// File: rtl/boreal_learning_sched.sv
// Hebbian weight-update sequencer: sweeps all synapse addresses once per pass,
// pairing each weight read with the latched error and one streamed mu word.
module boreal_learning_sched
  import boreal_pkg::*;
#(
  parameter int N_SYN  = 256,
  parameter int ADDR_W = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic                        abort,
  input  logic signed [BOREAL_DW-1:0] epsilon_in,
  input  logic                        mu_valid,
  output logic                        mu_ready,
  input  logic signed [BOREAL_DW-1:0] mu_data,
  output logic                        bram_en_a,
  output logic [ADDR_W-1:0]           bram_addr_a,
  output logic [ADDR_W-1:0]           bram_addr_b,
  output logic                        learn_enable,
  output logic signed [BOREAL_DW-1:0] learn_epsilon,
  output logic signed [BOREAL_DW-1:0] learn_mu,
  output logic                        busy,
  output logic                        done,
  output logic                        aborted,
  output logic [15:0]                 pass_count,
  output sched_state_e                dbg_state
);

  sched_state_e                r_state;
  logic [ADDR_W-1:0]           r_cnt;
  logic [1:0]                  r_drain;
  logic signed [BOREAL_DW-1:0] r_eps;
  logic                        r_en;
  logic [ADDR_W-1:0]           r_addr_a;
  logic [ADDR_W-1:0]           r_addr_b;
  logic signed [BOREAL_DW-1:0] r_eps_out;
  logic signed [BOREAL_DW-1:0] r_mu;
  logic                        r_done;
  logic                        r_aborted;
  logic [15:0]                 r_pass_count;

  logic w_fire;
  logic w_last;

  // mu stream: a word transfers on any cycle with mu_valid & mu_ready; ready is
  // high for the whole RUN state and never depends on mu_valid.
  assign mu_ready = (r_state == SCHED_RUN);
  assign w_fire   = mu_ready & mu_valid;
  assign w_last   = (r_cnt == ADDR_W'(N_SYN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SCHED_IDLE;
      r_cnt        <= '0;
      r_drain      <= '0;
      r_eps        <= '0;
      r_en         <= 1'b0;
      r_addr_a     <= '0;
      r_eps_out    <= '0;
      r_mu         <= '0;
      r_done       <= 1'b0;
      r_aborted    <= 1'b0;
      r_pass_count <= '0;
    end else begin
      r_en   <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        SCHED_IDLE: begin
          if (start) begin
            r_state   <= SCHED_RUN;
            r_eps     <= epsilon_in;
            r_cnt     <= '0;
            r_aborted <= 1'b0;
          end
        end
        SCHED_RUN: begin
          if (w_fire) begin
            r_en      <= 1'b1;
            r_addr_a  <= r_cnt;
            r_mu      <= mu_data;
            r_eps_out <= r_eps;
            r_cnt     <= r_cnt + ADDR_W'(1);
          end
          // An abort still lets a same-cycle fire through before draining.
          if ((w_fire && w_last) || abort) begin
            r_state <= SCHED_DRAIN;
            r_drain <= '0;
            if (abort) r_aborted <= 1'b1;
          end
        end
        SCHED_DRAIN: begin
          if (r_drain == 2'(SCHED_DRAIN_CYC - 1)) begin
            r_state      <= SCHED_DONE;
            r_done       <= 1'b1;
            r_pass_count <= r_pass_count + 16'd1;
          end else begin
            r_drain <= r_drain + 2'd1;
          end
        end
        SCHED_DONE: r_state <= SCHED_IDLE;
        default:    r_state <= SCHED_IDLE;
      endcase
    end
  end

  // Deliberately unreset so a write in flight at reset still lands correctly.
  always_ff @(posedge clk) begin
    r_addr_b <= r_addr_a;
  end

  assign bram_en_a     = r_en;
  assign bram_addr_a   = r_addr_a;
  assign bram_addr_b   = r_addr_b;
  assign learn_enable  = r_en;
  assign learn_epsilon = r_eps_out;
  assign learn_mu      = r_mu;
  assign busy          = (r_state != SCHED_IDLE);
  assign done          = r_done;
  assign aborted       = r_aborted;
  assign pass_count    = r_pass_count;
  assign dbg_state     = r_state;

endmodule
